// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared geometry, types and address helper for the sprite-box reader
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int RECT_W   = 27;
  localparam int RECT_H   = 48;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int IX_W     = $clog2(RECT_W);
  localparam int IY_W     = $clog2(RECT_H);

  typedef logic [7:0]          coord_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    coord_t  x;
    coord_t  y;
    colour_t colour;
  } pix_t;

  // py*160 + px built from shifts so no multiplier is needed
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] px, input logic [8:0] py);
    logic [17:0] sum;
    sum = ({9'd0, py} << 7) + ({9'd0, py} << 5) + {9'd0, px};
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/rect_reader_if.sv
// rtl/rect_reader_if.sv - control, framebuffer read port and pixel stream bundle
interface rect_reader_if;
  import draw_pkg::*;

  logic              start;
  coord_t            x_in;
  coord_t            y_in;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  colour_t           mem_q;
  coord_t            pix_x;
  coord_t            pix_y;
  colour_t           pix_colour;
  logic              pix_valid;
  logic              pix_ready;
  logic              done;

  modport master (
    output start, x_in, y_in, mem_q, pix_ready,
    input  busy, mem_addr, mem_rden, pix_x, pix_y, pix_colour, pix_valid, done
  );

  modport slave (
    input  start, x_in, y_in, mem_q, pix_ready,
    output busy, mem_addr, mem_rden, pix_x, pix_y, pix_colour, pix_valid, done
  );

endinterface

// File: rtl/rect_reader_fifo2.sv
// rtl/rect_reader_fifo2.sv - two-entry pixel FIFO with occupancy count
module pix_fifo2
  import draw_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  pix_t       data_i,
  input  logic       pop_i,
  output pix_t       head_o,
  output logic [1:0] count_o,
  output logic       valid_o
);

  pix_t       slot_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  // occupancy next state; push and pop together leave it unchanged
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // storage and ring pointers; a full push is only issued alongside a pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push_i) begin
        slot_q[wr_q] <= data_i;
        wr_q         <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = slot_q[rd_q];
  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/rect_reader.sv
// rtl/rect_reader.sv - scans a fixed rectangle of the framebuffer into a pixel stream
module rect_reader
  import draw_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  rect_reader_if.slave bus
);

  localparam logic [IX_W-1:0] IX_LAST = IX_W'(RECT_W - 1);
  localparam logic [IY_W-1:0] IY_LAST = IY_W'(RECT_H - 1);

  state_t            state_q, state_d;
  coord_t            x0_q, y0_q;
  logic [IX_W-1:0]   ix_q, ix_d;
  logic [IY_W-1:0]   iy_q, iy_d;
  logic              s1_valid_q, s1_on_q;
  coord_t            s1_x_q, s1_y_q;
  logic [ADDR_W-1:0] addr_q;

  logic [8:0] px, py;
  logic       on_screen, last_slot, issue, pop, rden, drained, fifo_valid;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  pix_t       push_data, head;

  // 9-bit coordinates so an origin near 255 carries out and lands off-screen
  assign px        = {1'b0, x0_q} + 9'(ix_q);
  assign py        = {1'b0, y0_q} + 9'(iy_q);
  assign on_screen = (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));
  assign last_slot = (ix_q == IX_LAST) && (iy_q == IY_LAST);
  assign pop       = fifo_valid && bus.pix_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, s1_valid_q};
  assign issue     = (state_q == SCAN) && ((occupancy - {2'b00, pop}) < 3'd2);
  assign rden      = issue && on_screen;
  assign drained   = !s1_valid_q && ((fifo_count - {1'b0, pop}) == 2'd0);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (issue && last_slot) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs and read port; the address holds across off-screen slots
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    bus.mem_rden = rden;
    bus.mem_addr = rden ? fb_addr(px, py) : addr_q;
  end

  // scan counters: cleared on an accepted start, advanced only when a slot issues
  always_comb begin
    ix_d = ix_q;
    iy_d = iy_q;
    if (state_q == IDLE && bus.start) begin
      ix_d = '0;
      iy_d = '0;
    end else if (issue) begin
      if (ix_q == IX_LAST) begin
        ix_d = '0;
        iy_d = iy_q + 1'b1;
      end else begin
        ix_d = ix_q + 1'b1;
      end
    end
  end

  // origin latch, counters and the in-flight stage waiting for mem_q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x0_q       <= '0;
      y0_q       <= '0;
      ix_q       <= '0;
      iy_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_on_q    <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      addr_q     <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        x0_q <= bus.x_in;
        y0_q <= bus.y_in;
      end
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      s1_valid_q <= issue;
      if (issue) begin
        s1_on_q <= on_screen;
        s1_x_q  <= px[7:0];
        s1_y_q  <= py[7:0];
      end
      if (rden) begin
        addr_q <= fb_addr(px, py);
      end
    end
  end

  assign push_data = {s1_x_q, s1_y_q, (s1_on_q ? bus.mem_q : colour_t'(0))};

  pix_fifo2 u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (s1_valid_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .valid_o (fifo_valid)
  );

  assign bus.pix_x      = head.x;
  assign bus.pix_y      = head.y;
  assign bus.pix_colour = head.colour;
  assign bus.pix_valid  = fifo_valid;

endmodule
